// File: rtl/reloj_bcd_bus_param.sv
// BCD time-of-day counter with a prescaled one-second step, 24 h or 12 h mode,
// addressed digit read/write, write validation and a registered read bus.
module reloj_bcd_bus_param #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned MODE12   = 0,
    parameter int unsigned DATA_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [2:0]        direccion,
    input  logic              we,
    input  logic [DATA_W-1:0] dato,
    output logic [DATA_W-1:0] BUS,
    output logic              seg_tick,
    output logic              werr,
    output logic              pm
);

    localparam int unsigned     CntW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);
    localparam logic            Mode12  = (MODE12 != 0);
    localparam logic [3:0]      UhRst   = Mode12 ? 4'd2 : 4'd0;
    localparam logic [3:0]      DhRst   = Mode12 ? 4'd1 : 4'd0;

    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        us_q, us_d, ds_q, ds_d, um_q, um_d;
    logic [3:0]        dm_q, dm_d, uh_q, uh_d, dh_q, dh_d;
    logic              pm_q, pm_d;
    logic [DATA_W-1:0] bus_q, bus_d;
    logic              tick_q, tick_d;
    logic              werr_q, werr_d;

    logic       step;
    logic       wr_ok;
    logic [3:0] wd;
    logic [3:0] rd_val;

    assign step = en && (cnt_q == CntLast);
    assign wd   = dato[3:0];

    assign BUS      = bus_q;
    assign seg_tick = tick_q;
    assign werr     = werr_q;
    assign pm       = Mode12 ? pm_q : 1'b0;

    if (DATA_W > 4) begin : g_dato_hi
        logic unused_dato_hi;
        assign unused_dato_hi = ^dato[DATA_W-1:4];
    end

    // Legal hour for the mode, given tens and units digits.
    function automatic logic hour_ok(input logic [3:0] d, input logic [3:0] u);
        logic [7:0] h;
        h = 8'(d) * 8'd10 + 8'(u);
        if (Mode12) begin
            return (h >= 8'd1) && (h <= 8'd12);
        end
        return h <= 8'd23;
    endfunction

    always_comb begin
        cnt_d  = cnt_q;
        us_d   = us_q;
        ds_d   = ds_q;
        um_d   = um_q;
        dm_d   = dm_q;
        uh_d   = uh_q;
        dh_d   = dh_q;
        pm_d   = pm_q;
        tick_d = 1'b0;
        werr_d = 1'b0;
        wr_ok  = 1'b0;
        rd_val = 4'd0;

        if (en) begin
            cnt_d = step ? '0 : cnt_q + 1'b1;
        end

        case (direccion)
            3'd0:    rd_val = us_q;
            3'd1:    rd_val = ds_q;
            3'd2:    rd_val = um_q;
            3'd3:    rd_val = dm_q;
            3'd4:    rd_val = uh_q;
            3'd5:    rd_val = dh_q;
            3'd6:    rd_val = {2'b00, Mode12, pm};
            default: rd_val = 4'd0;
        endcase
        bus_d      = '0;
        bus_d[3:0] = rd_val;

        // A write (accepted or not) takes the cycle; a coincident step is dropped.
        if (we) begin
            case (direccion)
                3'd0: begin
                    wr_ok = (wd <= 4'd9);
                    if (wr_ok) us_d = wd;
                end
                3'd1: begin
                    wr_ok = (wd <= 4'd5);
                    if (wr_ok) ds_d = wd;
                end
                3'd2: begin
                    wr_ok = (wd <= 4'd9);
                    if (wr_ok) um_d = wd;
                end
                3'd3: begin
                    wr_ok = (wd <= 4'd5);
                    if (wr_ok) dm_d = wd;
                end
                3'd4: begin
                    wr_ok = (wd <= 4'd9) && hour_ok(dh_q, wd);
                    if (wr_ok) uh_d = wd;
                end
                3'd5: begin
                    wr_ok = (wd <= 4'd2) && hour_ok(wd, uh_q);
                    if (wr_ok) dh_d = wd;
                end
                3'd6: begin
                    wr_ok = Mode12;
                    if (wr_ok) pm_d = dato[0];
                end
                default: wr_ok = 1'b0;
            endcase
            werr_d = !wr_ok;
        end else if (step) begin
            tick_d = 1'b1;
            if (us_q != 4'd9) begin
                us_d = us_q + 4'd1;
            end else begin
                us_d = 4'd0;
                if (ds_q != 4'd5) begin
                    ds_d = ds_q + 4'd1;
                end else begin
                    ds_d = 4'd0;
                    if (um_q != 4'd9) begin
                        um_d = um_q + 4'd1;
                    end else begin
                        um_d = 4'd0;
                        if (dm_q != 4'd5) begin
                            dm_d = dm_q + 4'd1;
                        end else begin
                            dm_d = 4'd0;
                            if (Mode12) begin
                                if (dh_q == 4'd1 && uh_q == 4'd2) begin
                                    dh_d = 4'd0;
                                    uh_d = 4'd1;
                                end else if (dh_q == 4'd1 && uh_q == 4'd1) begin
                                    uh_d = 4'd2;
                                    pm_d = !pm_q;
                                end else if (uh_q == 4'd9) begin
                                    uh_d = 4'd0;
                                    dh_d = 4'd1;
                                end else begin
                                    uh_d = uh_q + 4'd1;
                                end
                            end else begin
                                if (dh_q == 4'd2 && uh_q == 4'd3) begin
                                    dh_d = 4'd0;
                                    uh_d = 4'd0;
                                end else if (uh_q == 4'd9) begin
                                    uh_d = 4'd0;
                                    dh_d = dh_q + 4'd1;
                                end else begin
                                    uh_d = uh_q + 4'd1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            us_q   <= 4'd0;
            ds_q   <= 4'd0;
            um_q   <= 4'd0;
            dm_q   <= 4'd0;
            uh_q   <= UhRst;
            dh_q   <= DhRst;
            pm_q   <= 1'b0;
            bus_q  <= '0;
            tick_q <= 1'b0;
            werr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            us_q   <= us_d;
            ds_q   <= ds_d;
            um_q   <= um_d;
            dm_q   <= dm_d;
            uh_q   <= uh_d;
            dh_q   <= dh_d;
            pm_q   <= pm_d;
            bus_q  <= bus_d;
            tick_q <= tick_d;
            werr_q <= werr_d;
        end
    end

endmodule

// File: tb/tb_reloj_bcd_bus_param.sv
// Bench for reloj_bcd_bus_param: three configurations share one stimulus stream and are
// checked every cycle against a seconds-of-day model, plus literal directed checks.
module tb_reloj_bcd_bus_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       we;
    logic [2:0] direccion;
    logic [5:0] dato;

    logic [3:0] bus0;
    logic [5:0] bus1;
    logic [3:0] bus2;
    logic [2:0] seg;
    logic [2:0] werr;
    logic [2:0] pm;
    logic [5:0] busv [3];

    int n_cmp = 0;
    int n_bad = 0;

    // Model state per DUT: time as seconds since midnight (24 h basis), prescaler count.
    int m_t    [3];
    int m_cnt  [3];
    int m_bus  [3];
    int m_tick [3];
    int m_werr [3];

    assign busv[0] = {2'b00, bus0};
    assign busv[1] = bus1;
    assign busv[2] = {2'b00, bus2};

    always #5 clk = ~clk;

    reloj_bcd_bus_param #(.TICK_DIV(1), .MODE12(0), .DATA_W(4)) d0 (
        .clk(clk), .rst(rst), .en(en), .direccion(direccion), .we(we), .dato(dato[3:0]),
        .BUS(bus0), .seg_tick(seg[0]), .werr(werr[0]), .pm(pm[0])
    );
    reloj_bcd_bus_param #(.TICK_DIV(4), .MODE12(1), .DATA_W(6)) d1 (
        .clk(clk), .rst(rst), .en(en), .direccion(direccion), .we(we), .dato(dato),
        .BUS(bus1), .seg_tick(seg[1]), .werr(werr[1]), .pm(pm[1])
    );
    reloj_bcd_bus_param #(.TICK_DIV(1), .MODE12(1), .DATA_W(4)) d2 (
        .clk(clk), .rst(rst), .en(en), .direccion(direccion), .we(we), .dato(dato[3:0]),
        .BUS(bus2), .seg_tick(seg[2]), .werr(werr[2]), .pm(pm[2])
    );

    function automatic int m12_of(input int k);
        return (k == 0) ? 0 : 1;
    endfunction

    function automatic int td_of(input int k);
        return (k == 1) ? 4 : 1;
    endfunction

    function automatic int rd_model(input int t, input int m12, input int a);
        int s, mi, h, hd, pmv;
        s   = t % 60;
        mi  = (t / 60) % 60;
        h   = t / 3600;
        hd  = (m12 == 0) ? h : ((h % 12 == 0) ? 12 : h % 12);
        pmv = (m12 != 0 && h >= 12) ? 1 : 0;
        case (a)
            0:       return s % 10;
            1:       return s / 10;
            2:       return mi % 10;
            3:       return mi / 10;
            4:       return hd % 10;
            5:       return hd / 10;
            6:       return m12 * 2 + pmv;
            default: return 0;
        endcase
    endfunction

    // Returns 1 and the new time if the write is legal for the mode.
    function automatic bit wr_model(input int t, input int m12, input int a, input int d,
                                    output int nt);
        int dg [6];
        int hd, pmv, lim;
        nt = t;
        for (int i = 0; i < 6; i++) dg[i] = rd_model(t, m12, i);
        pmv = rd_model(t, m12, 6) % 2;
        if (a == 7) return 1'b0;
        if (a == 6) begin
            if (m12 == 0) return 1'b0;
            pmv = d % 2;
        end else begin
            lim = (a == 1 || a == 3) ? 5 : ((a == 5) ? 2 : 9);
            if (d > lim) return 1'b0;
            dg[a] = d;
        end
        hd = dg[5] * 10 + dg[4];
        if (m12 != 0) begin
            if (hd < 1 || hd > 12) return 1'b0;
            hd = hd % 12 + 12 * pmv;
        end else if (hd > 23) begin
            return 1'b0;
        end
        nt = hd * 3600 + (dg[3] * 10 + dg[2]) * 60 + dg[1] * 10 + dg[0];
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input int k, input logic [5:0] got, input int exp);
        n_cmp++;
        if (got !== 6'(exp)) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0d, expected %0d", nm, k, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        we        = 1'b1;
        direccion = 3'(a);
        dato      = 6'(d);
        cyc();
        we = 1'b0;
    endtask

    task automatic rd(input int a);
        direccion = 3'(a);
        cyc();
    endtask

    // Reference model, advanced on every active edge.
    initial begin
        int  nt;
        bit  st;
        for (int k = 0; k < 3; k++) begin
            m_t[k] = 0; m_cnt[k] = 0; m_bus[k] = 0; m_tick[k] = 0; m_werr[k] = 0;
        end
        forever begin
            @(posedge clk or posedge rst);
            for (int k = 0; k < 3; k++) begin
                if (rst) begin
                    m_t[k] = 0; m_cnt[k] = 0; m_bus[k] = 0; m_tick[k] = 0; m_werr[k] = 0;
                end else begin
                    st = en && (m_cnt[k] == td_of(k) - 1);
                    if (en) m_cnt[k] = st ? 0 : m_cnt[k] + 1;
                    m_bus[k]  = rd_model(m_t[k], m12_of(k), int'(direccion));
                    m_tick[k] = 0;
                    m_werr[k] = 0;
                    if (we) begin
                        if (wr_model(m_t[k], m12_of(k), int'(direccion), int'(dato[3:0]), nt))
                            m_t[k] = nt;
                        else
                            m_werr[k] = 1;
                    end else if (st) begin
                        m_t[k]    = (m_t[k] + 1) % 86400;
                        m_tick[k] = 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk("bus", k, busv[k], m_bus[k]);
                chk("seg_tick", k, {5'b0, seg[k]}, m_tick[k]);
                chk("werr", k, {5'b0, werr[k]}, m_werr[k]);
                chk("pm", k, {5'b0, pm[k]}, rd_model(m_t[k], m12_of(k), 6) % 2);
            end
        end
    end

    initial begin
        int cnt;
        int e [6];
        rst = 1'b1; en = 1'b0; we = 1'b0; direccion = 3'd0; dato = 6'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_bus", 0, busv[0], 0);
        chk("reset_pm", 2, {5'b0, pm[2]}, 0);
        rd(6);
        chk("reset_status", 2, busv[2], 2);
        chk("reset_status", 0, busv[0], 0);

        // 24 h rollover through midnight
        wr(0, 8); wr(1, 5); wr(2, 9); wr(3, 5); wr(4, 3); wr(5, 2);
        en = 1'b1; cyc(); en = 1'b0;
        chk("tick_235959", 0, {5'b0, seg[0]}, 1);
        e = '{9, 5, 9, 5, 3, 2};
        for (int a = 5; a >= 0; a--) begin
            rd(a);
            chk($sformatf("t235959_a%0d", a), 0, busv[0], e[a]);
        end
        en = 1'b1; cyc(); en = 1'b0;
        chk("tick_midnight", 0, {5'b0, seg[0]}, 1);
        for (int a = 5; a >= 0; a--) begin
            rd(a);
            chk($sformatf("t000000_a%0d", a), 0, busv[0], 0);
        end

        // 12 h: 11:59:59 AM -> 12:00:00 PM, then 12:59:59 PM -> 01:00:00 PM
        wr(5, 1); wr(4, 1); wr(3, 5); wr(2, 9); wr(1, 5); wr(0, 9); wr(6, 0);
        en = 1'b1; cyc(); en = 1'b0;
        chk("tick_noon", 2, {5'b0, seg[2]}, 1);
        chk("pm_noon", 2, {5'b0, pm[2]}, 1);
        e = '{0, 0, 0, 0, 2, 1};
        for (int a = 5; a >= 0; a--) begin
            rd(a);
            chk($sformatf("t12pm_a%0d", a), 2, busv[2], e[a]);
        end
        rd(6);
        chk("status_pm", 2, busv[2], 3);
        wr(4, 2); wr(3, 5); wr(2, 9); wr(1, 5); wr(0, 9);
        en = 1'b1; cyc(); en = 1'b0;
        chk("pm_one", 2, {5'b0, pm[2]}, 1);
        rd(5);
        chk("t01_dh", 2, busv[2], 0);
        rd(4);
        chk("t01_uh", 2, busv[2], 1);

        // Illegal writes in 24 h mode (DUT0 at 13:00:00)
        wr(5, 1); wr(4, 5);
        wr(0, 10);
        chk("werr_us10", 0, {5'b0, werr[0]}, 1);
        wr(1, 6);
        chk("werr_ds6", 0, {5'b0, werr[0]}, 1);
        wr(5, 2);
        chk("werr_dh2_uh5", 0, {5'b0, werr[0]}, 1);
        wr(7, 0);
        chk("werr_addr7", 0, {5'b0, werr[0]}, 1);
        e = '{0, 0, 0, 0, 5, 1};
        for (int a = 0; a < 6; a++) begin
            rd(a);
            chk($sformatf("t150000_a%0d", a), 0, busv[0], e[a]);
        end
        wr(4, 0); wr(5, 2); wr(4, 3);
        chk("werr_uh3_dh2", 0, {5'b0, werr[0]}, 0);
        rd(4);
        chk("uh3_accepted", 0, busv[0], 3);

        // Write coinciding with a step: write wins, tick lost
        wr(0, 0);
        en = 1'b1;
        wr(0, 5);
        chk("no_tick_on_write", 0, {5'b0, seg[0]}, 0);
        cyc();
        chk("tick_after_write", 0, {5'b0, seg[0]}, 1);
        en = 1'b0;
        rd(0);
        chk("us_after_write", 0, busv[0], 6);
        chk("us_after_write", 2, busv[2], 6);

        // Prescaler of 4: 10 pulses in 40 enabled cycles, none while disabled
        cnt = 0;
        en  = 1'b1;
        repeat (40) begin
            cyc();
            if (seg[1] === 1'b1) cnt++;
        end
        chk("pulses_40", 1, 6'(cnt), 10);
        en  = 1'b0;
        cnt = 0;
        repeat (12) begin
            cyc();
            if (seg[1] === 1'b1) cnt++;
        end
        chk("pulses_en0", 1, 6'(cnt), 0);

        // Randomised traffic
        repeat (2000) begin
            en        = ($urandom_range(0, 9) < 8);
            we        = ($urandom_range(0, 9) == 0);
            direccion = 3'($urandom_range(0, 7));
            dato      = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                    : 6'($urandom_range(0, 9));
            cyc();
        end
        we = 1'b0;

        // Asynchronous reset in the middle of a prescaler count
        en = 1'b1;
        repeat (6) cyc();
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("async_rst_bus", k, busv[k], 0);
            chk("async_rst_pm", k, {5'b0, pm[k]}, 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        en = 1'b0;
        e = '{0, 0, 0, 0, 2, 1};
        for (int a = 5; a >= 0; a--) begin
            rd(a);
            chk($sformatf("rst12_a%0d", a), 1, busv[1], e[a]);
            chk($sformatf("rst12_a%0d", a), 2, busv[2], e[a]);
        end
        rd(6);
        chk("rst_status", 1, busv[1], 2);
        chk("rst_status", 2, busv[2], 2);
        chk("rst_status", 0, busv[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reloj_bcd_bus_param.md
Name: reloj_bcd_bus_param

Overview:
- Parametrised BCD time-of-day counter with a prescaled 1 Hz time base.
- Supports 24 h mode and 12 h mode with an AM/PM flag.
- Each digit can be read through an addressed bus and written through an addressed bus.
- Sits on the system address/data bus as a timekeeping peripheral; successor of the fixed 24 h bus-read clock.
- Adds a rollover that is correct by construction, time setting, a run enable and a status word.

Parameters:
- TICK_DIV, 50000000: clk cycles per one-second step. Minimum 1; with 1, every enabled cycle is a step.
- MODE12, 0: 0 selects 24 h (00:00:00..23:59:59); 1 selects 12 h (12:00:00..11:59:59 plus PM flag).
- DATA_W, 4: BUS and dato width. Minimum 4; digits are zero-extended.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; when 0, prescaler and time hold.
- direccion  in  3  digit/register select: 0 Us, 1 Ds, 2 Um, 3 Dm, 4 Uh, 5 Dh, 6 status, 7 reserved.
- we  in  1  write strobe, single-cycle, sampled with direccion/dato.
- dato  in  DATA_W  write data; only bits [3:0] are used.
- BUS  out  DATA_W  registered read data.
- seg_tick  out  1  one-cycle pulse on every one-second step.
- werr  out  1  one-cycle pulse when a write is rejected.
- pm  out  1  PM flag; constant 0 when MODE12=0.

Behaviour:
- Reset (async, immediate)
  - MODE12=0: time 00:00:00.
  - MODE12=1: time 12:00:00, pm=0.
  - Prescaler=0; BUS=0, seg_tick=0, werr=0.
- Prescaler
  - Counts 0..TICK_DIV-1 while en=1.
  - Step asserted in the cycle the count equals TICK_DIV-1; the count then returns to 0.
  - When en=0, the count holds and no step occurs.
- Step carry chain
  - Us 9->0 carries to Ds; Ds 5->0 carries to Um; Um 9->0 carries to Dm; Dm 5->0 carries to hours.
  - 24 h hours: 23->00; otherwise Uh 9->0 with Dh+1.
  - 12 h hours: 12->01; 09->10; 11->12 toggles pm.
  - The whole step resolves in one cycle.
  - Digits never hold out-of-range values: Us/Um/Uh 0..9, Ds/Dm 0..5, Dh 0..2.
- seg_tick: registered pulse in the cycle after the step edge, coincident with the new time being visible.
- Write (we=1)
  - Target is selected by direccion.
  - Accepted if the digit range holds and the resulting hour is legal for the mode:
    - 24 h: 00..23.
    - 12 h: 01..12.
  - Uh writes are checked against the current Dh; Dh writes against the current Uh.
  - Address 6 write: bit0 sets pm (MODE12=1 only, otherwise rejected).
  - Address 7 write is always rejected.
  - Rejected write: no state change; werr=1 for the following cycle.
- Write vs step in the same cycle
  - The write wins and the time step of that cycle is discarded (the tick is lost).
  - The prescaler still wraps, and seg_tick is not pulsed.
- Read
  - BUS = selected register, one clock of latency (direccion sampled at edge N, data valid after edge N).
  - The value reflects time after edge N-1 updates.
  - Addr 6 = {DATA_W-2 zeros, MODE12, pm}; addr 7 = 0.
  - Reading a digit written in the same cycle returns the old value; the new value is returned one cycle later.
- Reset asserted mid-step or mid-write: reset dominates, with no partial update.
- en changes take effect at the next edge; a write while en=0 is still performed.

Test Plan:
- TICK_DIV=1, MODE12=0: write 23:59:58, run 2 cycles -> reads 23:59:59 then 00:00:00 on addrs 5..0; seg_tick pulses twice.
- TICK_DIV=4: count seg_tick over 40 cycles with en=1 -> exactly 10 pulses; deassert en 12 cycles -> 0 pulses and time unchanged.
- MODE12=1, TICK_DIV=1: set 11:59:59 pm=0, step -> 12:00:00 pm=1; set 12:59:59, step -> 01:00:00 pm unchanged.
- Illegal writes in MODE12=0: Us=10, Ds=6, Dh=2 with Uh=5, addr 7 -> werr=1 each, time unchanged. Uh=3 with Dh=2 -> accepted.
- TICK_DIV=1: we on addr 0 with dato=5 during a step -> Us=5, no increment that cycle, no seg_tick; next cycle Us=6.
- Assert rst asynchronously mid-count in MODE12=1 -> BUS=0 immediately; reads give 12:00:00, pm=0; status read gives 2 (MODE12=1, pm=0).
